// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_unit_pkg;

  localparam int unsigned IFU_ADDR_W   = 30;
  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] IFU_NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2,
    S_VALID = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory req/ready bus between the fetch unit (master) and memory (slave).
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = instr_fetch_unit_pkg::IFU_ADDR_W
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ready);
  modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ready);
endinterface

// File: rtl/instr_fetch_unit_next_pc.sv
// Next-PC select: redirect target over sequential pc+4 over hold.
module ifu_next_pc (
  input  logic [31:0] i_pc,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_advance,
  output logic [31:0] o_next_pc,
  output logic [31:0] o_pc_plus4
);

  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = i_pc + 32'd4;
  assign o_pc_plus4 = w_pc_plus4;

  always_comb begin
    o_next_pc = i_pc;
    if (i_redirect_valid) begin
      o_next_pc = i_redirect_pc & 32'hFFFF_FFFC;
    end else if (i_advance) begin
      o_next_pc = w_pc_plus4;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues word fetches, holds the IR, squashes wrong-path data.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter int unsigned ADDR_W   = IFU_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  instr_fetch_unit_if.master        mem,
  input  logic                      instr_accept,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  output logic [31:0]               instr,
  output logic                      instr_valid,
  output logic [5:0]                Op,
  output logic [5:0]                funct,
  output logic [31:0]               pc,
  output logic [31:0]               pc_plus4,
  output logic [31:0]               fetch_count
);

  ifu_state_e        r_state, w_state_nxt;
  logic [31:0]       r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_fetch_addr, w_fetch_addr_nxt;
  logic [31:0]       r_ir, w_ir_nxt;
  logic              r_instr_valid, w_instr_valid_nxt;
  logic              r_mem_req, w_mem_req_nxt;
  logic [31:0]       r_fetch_count, w_fetch_count_nxt;
  logic [31:0]       w_next_pc;
  logic [31:0]       w_pc_plus4;
  logic              w_advance;

  assign w_advance = (r_state == S_VALID) && instr_accept;

  ifu_next_pc u_next_pc (
    .i_pc             (r_pc),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_advance        (w_advance),
    .o_next_pc        (w_next_pc),
    .o_pc_plus4       (w_pc_plus4)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_fetch_addr  <= RESET_PC[ADDR_W+1:2];
      r_ir          <= IFU_NOP;
      r_instr_valid <= 1'b0;
      r_mem_req     <= 1'b0;
      r_fetch_count <= 32'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_fetch_addr  <= w_fetch_addr_nxt;
      r_ir          <= w_ir_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_fetch_count <= w_fetch_count_nxt;
    end
  end

  // An issued request is never altered: fetch_addr only moves when the bus is idle or completing.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_fetch_addr_nxt  = r_fetch_addr;
    w_ir_nxt          = r_ir;
    w_instr_valid_nxt = r_instr_valid;
    w_fetch_count_nxt = r_fetch_count;
    case (r_state)
      S_IDLE: begin
        w_pc_nxt         = w_next_pc;
        w_fetch_addr_nxt = w_next_pc[ADDR_W+1:2];
        w_state_nxt      = S_FETCH;
      end
      S_FETCH: begin
        if (mem.mem_ready) begin
          if (redirect_valid) begin
            w_pc_nxt         = w_next_pc;
            w_fetch_addr_nxt = w_next_pc[ADDR_W+1:2];
          end else begin
            w_ir_nxt          = mem.mem_rdata;
            w_instr_valid_nxt = 1'b1;
            w_state_nxt       = S_VALID;
          end
        end else if (redirect_valid) begin
          w_pc_nxt    = w_next_pc;
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_pc_nxt = w_next_pc;
        if (mem.mem_ready) begin
          w_fetch_addr_nxt = w_next_pc[ADDR_W+1:2];
          w_state_nxt      = S_FETCH;
        end
      end
      S_VALID: begin
        if (instr_accept || redirect_valid) begin
          w_pc_nxt          = w_next_pc;
          w_fetch_addr_nxt  = w_next_pc[ADDR_W+1:2];
          w_instr_valid_nxt = 1'b0;
          w_state_nxt       = S_FETCH;
          if (instr_accept) begin
            w_fetch_count_nxt = r_fetch_count + 32'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_mem_req_nxt = (w_state_nxt == S_FETCH) || (w_state_nxt == S_FLUSH);
  end

  assign mem.mem_req  = r_mem_req;
  assign mem.mem_addr = r_fetch_addr;
  assign instr        = r_ir;
  assign instr_valid  = r_instr_valid;
  assign pc           = r_pc;
  assign fetch_count  = r_fetch_count;
  assign Op           = r_ir[31:26];
  assign funct        = r_ir[5:0];
  assign pc_plus4     = w_pc_plus4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, async reset sequence, randomized run vs reference model.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_accept = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] instr, pc, pc_plus4, fetch_count;
  logic        instr_valid;
  logic [5:0]  Op, funct;

  int vectors = 0;
  int miscompares = 0;

  instr_fetch_unit_if #(.ADDR_W(30)) mem_if ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(30)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem            (mem_if),
    .instr_accept   (instr_accept),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .Op             (Op),
    .funct          (funct),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic [31:0] rdata;
    logic        accept;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [29:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
    logic [31:0] e_cnt;
    logic [31:0] e_instr;
  } vec_t;

  localparam int NVEC = 26;
  vec_t tbl [NVEC];

  // Reference model state: an outstanding request that may be marked wrong-path.
  logic        m_start, m_req, m_valid, m_squash;
  logic [31:0] m_pc, m_cnt, m_ir;
  logic [29:0] m_addr;

  function automatic logic [31:0] memf(input logic [29:0] a);
    return ({2'b00, a} * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  task automatic cmp(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s %s: got %h expected %h (t=%0t)", tag, nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic req, input logic [29:0] addr,
                               input logic iv, input logic [31:0] pc_e, input logic [31:0] cnt_e,
                               input logic [31:0] instr_e);
    vectors++;
    cmp(tag, "mem_req",     32'(mem_if.mem_req),  32'(req));
    cmp(tag, "mem_addr",    32'(mem_if.mem_addr), 32'(addr));
    cmp(tag, "instr_valid", 32'(instr_valid),     32'(iv));
    cmp(tag, "pc",          pc,                   pc_e);
    cmp(tag, "pc_plus4",    pc_plus4,             pc_e + 32'd4);
    cmp(tag, "fetch_count", fetch_count,          cnt_e);
    cmp(tag, "instr",       instr,                instr_e);
    cmp(tag, "Op",          32'(Op),              32'(instr_e[31:26]));
    cmp(tag, "funct",       32'(funct),           32'(instr_e[5:0]));
  endtask

  task automatic model_reset();
    m_start = 1'b1; m_req = 1'b0; m_valid = 1'b0; m_squash = 1'b0;
    m_pc = 32'h0; m_cnt = 32'h0; m_ir = 32'h0; m_addr = 30'h0;
  endtask

  task automatic model_step(input logic rdy, input logic acc, input logic red, input logic [31:0] rpc);
    if (m_start) begin
      m_start = 1'b0;
      m_req   = 1'b1;
    end else if (m_valid) begin
      if (acc || red) begin
        if (acc) m_cnt = m_cnt + 32'd1;
        m_pc    = red ? (rpc & 32'hFFFF_FFFC) : m_pc + 32'd4;
        m_addr  = m_pc[31:2];
        m_valid = 1'b0;
        m_req   = 1'b1;
      end
    end else begin
      if (red) m_pc = rpc & 32'hFFFF_FFFC;
      if (rdy) begin
        if (m_squash || red) begin
          m_addr   = m_pc[31:2];
          m_squash = 1'b0;
        end else begin
          m_ir    = memf(m_addr);
          m_valid = 1'b1;
          m_req   = 1'b0;
        end
      end else if (red) begin
        m_squash = 1'b1;
      end
    end
  endtask

  initial begin
    // ready rdata accept redir rpc | req addr iv pc cnt instr
    tbl[0]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 30'h0,        1'b0, 32'h0,         32'd0, 32'h0};
    tbl[1]  = '{1'b1, 32'h8C08_0004, 1'b0, 1'b0, 32'h0,         1'b0, 30'h0,        1'b1, 32'h0,         32'd0, 32'h8C08_0004};
    tbl[2]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 30'h1,        1'b0, 32'h4,         32'd1, 32'h8C08_0004};
    tbl[3]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 30'h1,        1'b0, 32'h4,         32'd1, 32'h8C08_0004};
    tbl[4]  = '{1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0,         1'b0, 30'h1,        1'b1, 32'h4,         32'd1, 32'h1111_1111};
    tbl[5]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 30'h2,        1'b0, 32'h8,         32'd2, 32'h1111_1111};
    tbl[6]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 30'h2,        1'b0, 32'h8,         32'd2, 32'h1111_1111};
    tbl[7]  = '{1'b1, 32'h2222_2222, 1'b0, 1'b0, 32'h0,         1'b0, 30'h2,        1'b1, 32'h8,         32'd2, 32'h2222_2222};
    tbl[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 30'h3,        1'b0, 32'hC,         32'd3, 32'h2222_2222};
    tbl[9]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h40,        1'b1, 30'h3,        1'b0, 32'h40,        32'd3, 32'h2222_2222};
    tbl[10] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 30'h3,        1'b0, 32'h40,        32'd3, 32'h2222_2222};
    tbl[11] = '{1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0,         1'b1, 30'h10,       1'b0, 32'h40,        32'd3, 32'h2222_2222};
    tbl[12] = '{1'b1, 32'h4444_4444, 1'b0, 1'b0, 32'h0,         1'b0, 30'h10,       1'b1, 32'h40,        32'd3, 32'h4444_4444};
    tbl[13] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h100,       1'b1, 30'h40,       1'b0, 32'h100,       32'd4, 32'h4444_4444};
    tbl[14] = '{1'b1, 32'h5555_5555, 1'b0, 1'b1, 32'h203,       1'b1, 30'h80,       1'b0, 32'h200,       32'd4, 32'h4444_4444};
    tbl[15] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h300,       1'b1, 30'h80,       1'b0, 32'h300,       32'd4, 32'h4444_4444};
    tbl[16] = '{1'b1, 32'hABCD_0000, 1'b0, 1'b1, 32'h400,       1'b1, 30'h100,      1'b0, 32'h400,       32'd4, 32'h4444_4444};
    tbl[17] = '{1'b1, 32'h6666_6666, 1'b0, 1'b0, 32'h0,         1'b0, 30'h100,      1'b1, 32'h400,       32'd4, 32'h6666_6666};
    tbl[18] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h500,       1'b1, 30'h140,      1'b0, 32'h500,       32'd4, 32'h6666_6666};
    tbl[19] = '{1'b1, 32'h7777_7777, 1'b0, 1'b0, 32'h0,         1'b0, 30'h140,      1'b1, 32'h500,       32'd4, 32'h7777_7777};
    tbl[20] = '{1'b1, 32'hEEEE_EEEE, 1'b0, 1'b0, 32'h0,         1'b0, 30'h140,      1'b1, 32'h500,       32'd4, 32'h7777_7777};
    tbl[21] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 30'h3FFF_FFFF, 1'b0, 32'hFFFF_FFFC, 32'd4, 32'h7777_7777};
    tbl[22] = '{1'b1, 32'h8888_8888, 1'b0, 1'b0, 32'h0,         1'b0, 30'h3FFF_FFFF, 1'b1, 32'hFFFF_FFFC, 32'd4, 32'h8888_8888};
    tbl[23] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 30'h0,        1'b0, 32'h0,         32'd5, 32'h8888_8888};
    tbl[24] = '{1'b1, 32'h9999_9999, 1'b0, 1'b0, 32'h0,         1'b0, 30'h0,        1'b1, 32'h0,         32'd5, 32'h9999_9999};
    tbl[25] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 30'h1,        1'b0, 32'h4,         32'd6, 32'h9999_9999};

    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = 32'h0;

    // Reset state, then directed table
    repeat (2) @(negedge clk);
    check_outputs("reset", 1'b0, 30'h0, 1'b0, 32'h0, 32'd0, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      mem_if.mem_ready = tbl[i].ready;
      mem_if.mem_rdata = tbl[i].rdata;
      instr_accept     = tbl[i].accept;
      redirect_valid   = tbl[i].redir;
      redirect_pc      = tbl[i].rpc;
      @(posedge clk);
      @(negedge clk);
      check_outputs($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_iv,
                    tbl[i].e_pc, tbl[i].e_cnt, tbl[i].e_instr);
    end

    // Asynchronous reset in the middle of a pending fetch
    mem_if.mem_ready = 1'b0;
    instr_accept     = 1'b0;
    redirect_valid   = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_outputs("rst_async", 1'b0, 30'h0, 1'b0, 32'h0, 32'd0, 32'h0);
    mem_if.mem_ready = 1'b1;
    mem_if.mem_rdata = 32'hFACE_FACE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs("rst_held", 1'b0, 30'h0, 1'b0, 32'h0, 32'd0, 32'h0);
    rst_n = 1'b1;
    model_reset();

    // Randomized run against the reference model
    for (int c = 0; c < 3000; c++) begin
      logic        rdy, acc, red;
      logic [31:0] rpc;
      check_outputs("rnd", m_req, m_addr, m_valid, m_pc, m_cnt, m_ir);
      rdy = ($urandom_range(0, 1) == 1);
      acc = ($urandom_range(0, 1) == 1);
      red = ($urandom_range(0, 99) < 15) && !m_start;
      rpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
      mem_if.mem_ready = rdy;
      mem_if.mem_rdata = memf(mem_if.mem_addr);
      instr_accept     = acc;
      redirect_valid   = red;
      redirect_pc      = rpc;
      model_step(rdy, acc, red, rpc);
      @(posedge clk);
      @(negedge clk);
    end
    check_outputs("rnd_last", m_req, m_addr, m_valid, m_pc, m_cnt, m_ir);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage that sits directly upstream of main_control in the Multicycle_MIPS core. It owns the PC and issues word-addressed requests to instruction memory/I-cache using a req/ready handshake. It holds the returned word in an instruction register (IR) and presents Op/funct straight to the decoder.
It takes PC redirects from branch, jump and jr, and discards in-flight fetches on the wrong path.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
ADDR_W, 30, instruction memory word-address width (byte PC bits [31:2])

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
mem_req  output  1  fetch request to instruction memory
mem_addr  output  ADDR_W  word address of the current request
mem_rdata  input  32  instruction word, valid when mem_ready=1
mem_ready  input  1  memory completes the current request this cycle
instr_accept  input  1  core consumes the held instruction this cycle
redirect_valid  input  1  take redirect_pc (branch taken, j, jal, jr)
redirect_pc  input  32  redirect target byte address; bits [1:0] ignored (treated as 0)
instr  output  32  IR contents
instr_valid  output  1  IR holds a fetched instruction for the current PC
Op  output  6  instr[31:26], feeds main_control
funct  output  6  instr[5:0], feeds main_control
pc  output  32  byte address of the instruction in IR / being fetched
pc_plus4  output  32  pc + 4, wraps modulo 2^32, used for jal link
fetch_count  output  32  count of accepted instructions, wraps

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=S_IDLE; pc=RESET_PC; fetch_addr=RESET_PC[31:2]
  - instr=32'h0 (NOP); instr_valid=0; mem_req=0; fetch_count=0
- S_IDLE: lasts exactly one cycle after reset release, then S_FETCH.
- S_FETCH:
  - mem_req=1; mem_addr=fetch_addr; both held stable until mem_ready.
  - mem_ready=1 and no redirect: IR<=mem_rdata; instr_valid<=1; go to S_VALID. Minimum latency is one cycle from entering S_FETCH to instr_valid=1.
  - mem_ready=1 with redirect_valid=1 in the same cycle: discard mem_rdata; pc<=redirect_pc; fetch_addr<=redirect_pc[31:2]; stay in S_FETCH. The new request goes out next cycle with mem_req still 1.
  - redirect_valid=1 without mem_ready: pc<=redirect_pc; go to S_FLUSH. fetch_addr is unchanged, because an issued request is never cancelled or altered.
- S_FLUSH:
  - mem_req=1 with the old fetch_addr until mem_ready.
  - On mem_ready: discard data; fetch_addr<=pc[31:2]; go to S_FETCH.
  - A further redirect in S_FLUSH: pc<=redirect_pc; the last redirect wins.
  - instr_valid=0 throughout.
- S_VALID:
  - mem_req=0; IR, pc and instr_valid held.
  - instr_accept=1: fetch_count<=fetch_count+1; next pc = redirect_valid ? redirect_pc : pc+4; fetch_addr = next pc[31:2]; instr_valid<=0; go to S_FETCH.
  - redirect_valid=1 without accept: pc<=redirect_pc; instr_valid<=0; go to S_FETCH. fetch_count is unchanged.
- Priority: redirect over sequential pc+4 everywhere.
- instr_accept outside S_VALID is ignored.
- While instr_valid=0, IR keeps its last value. Downstream must qualify with instr_valid.
- Op, funct and pc_plus4 are combinational from IR and pc; all other outputs are registered.
- PC increments wrap at 32'hFFFF_FFFC -> 32'h0000_0000.
- Reset mid-fetch: outputs go to reset values immediately. Memory-side responses after reset with no mem_req outstanding are ignored.

Decomposition:
- Shared package holds:
  - state encoding (S_IDLE, S_FETCH, S_FLUSH, S_VALID, 2 bits)
  - NOP constant 32'h0
  - default RESET_PC
  - word-address width
- One natural sub-module: ifu_next_pc, the combinational next-PC select (redirect / pc+4 / hold) with pc_plus4 generation.

Test Plan:
- Reset, then mem_ready=1 on the first request, rdata=32'h8C08_0004 -> mem_addr=0; instr_valid=1 one cycle later; Op=6'h23; pc=0.
- Accept three instructions with 2-cycle memory latency -> mem_addr=0,1,2; pc=0,4,8; fetch_count=3; mem_addr stable while mem_ready=0.
- redirect_pc=32'h40 while the fetch of 0x4 is pending (mem_ready=0) -> enter S_FLUSH; the 0x4 data is discarded; next mem_addr=32'h10; instr_valid stays 0 until the 0x40 word returns.
- redirect and mem_ready in the same cycle in S_FETCH -> data dropped; next mem_addr=redirect_pc[31:2]; no instr_valid pulse.
- In S_VALID, instr_accept=1 with redirect_pc=32'h100 -> next mem_addr=32'h40; fetch_count increments by 1.
- Assert rst_n=0 mid-fetch -> mem_req=0, instr_valid=0, pc=0 asynchronously; the sequence restarts at address 0.
